unified_mem_arbiter: RTL and testbench

UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

---
 rtl/unified_mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Arbitrates a single shared memory port between the instruction fetch
//   stage and the load/store (MEM) stage. Only one access is outstanding at
//   a time. Both requesters pending: grants alternate, starting with data.
//   A wait counter bounds each access. When it expires the access is
//   terminated with an ack, read data of zero and a sticky timeout flag.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   inst_addr, inst_req   : fetch request (held until inst_ack)
//   instr, inst_ack       : registered fetch data, one-cycle completion pulse
//   data_addr, data_out   : load/store address and store data
//   mem_read, mem_write   : load/store request (held until data_ack)
//   data_in, data_ack     : registered load data, one-cycle completion pulse
//   stall                 : combinational pipeline freeze request
//   m_addr, m_wdata       : registered shared memory address / write data
//   m_rd, m_wr            : registered shared memory strobes
//   m_rdata, m_ready      : shared memory read data / completion
//   timeout_err           : sticky timeout flag, cleared only by reset
module unified_mem_arbiter #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst_addr,
  input  logic        inst_req,
  output logic [31:0] instr,
  output logic        inst_ack,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_out,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] data_in,
  output logic        data_ack,
  output logic        stall,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_rd,
  output logic        m_wr,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        timeout_err
);

  localparam int unsigned CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2
  } arbStateT;

  arbStateT    state, stateNxt;
  logic [CW-1:0] waitCnt, waitCntNxt;
  logic        lastGrantData, lastGrantDataNxt;

  logic [31:0] instrNxt, dataInNxt, mAddrNxt, mWdataNxt;
  logic        mRdNxt, mWrNxt, instAckNxt, dataAckNxt, timeoutNxt;

  logic        dataPend, instPend;
  logic        grantData, grantInst, accDone, accTimeout;

  // A requester whose ack is high this cycle is still holding its request
  // line; mask it so the same transfer is not granted twice.
  assign dataPend = (mem_read | mem_write) & ~data_ack;
  assign instPend = inst_req & ~inst_ack;

  assign stall = (inst_req & ~inst_ack) | ((mem_read | mem_write) & ~data_ack);

  // State register (and registered outputs)
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      waitCnt       <= '0;
      lastGrantData <= 1'b0;
      instr         <= '0;
      data_in       <= '0;
      m_addr        <= '0;
      m_wdata       <= '0;
      m_rd          <= 1'b0;
      m_wr          <= 1'b0;
      inst_ack      <= 1'b0;
      data_ack      <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= stateNxt;
      waitCnt       <= waitCntNxt;
      lastGrantData <= lastGrantDataNxt;
      instr         <= instrNxt;
      data_in       <= dataInNxt;
      m_addr        <= mAddrNxt;
      m_wdata       <= mWdataNxt;
      m_rd          <= mRdNxt;
      m_wr          <= mWrNxt;
      inst_ack      <= instAckNxt;
      data_ack      <= dataAckNxt;
      timeout_err   <= timeoutNxt;
    end
  end

  // Next-state logic
  always_comb begin
    grantData  = 1'b0;
    grantInst  = 1'b0;
    accDone    = 1'b0;
    accTimeout = 1'b0;
    stateNxt   = state;
    unique case (state)
      IDLE: begin
        if (dataPend && !(lastGrantData && instPend)) begin
          grantData = 1'b1;
          stateNxt  = DATA;
        end else if (instPend) begin
          grantInst = 1'b1;
          stateNxt  = INST;
        end
      end
      DATA, INST: begin
        if (m_ready) begin
          accDone  = 1'b1;
          stateNxt = IDLE;
        end else if (waitCnt == WAIT_LIM) begin
          accTimeout = 1'b1;
          stateNxt   = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    instrNxt         = instr;
    dataInNxt        = data_in;
    mAddrNxt         = m_addr;
    mWdataNxt        = m_wdata;
    mRdNxt           = m_rd;
    mWrNxt           = m_wr;
    instAckNxt       = 1'b0;
    dataAckNxt       = 1'b0;
    timeoutNxt       = timeout_err;
    waitCntNxt       = waitCnt;
    lastGrantDataNxt = lastGrantData;

    if (grantData) begin
      // Both strobes high from the MEM stage is treated as a store.
      mAddrNxt         = data_addr;
      mWrNxt           = mem_write;
      mRdNxt           = ~mem_write;
      if (mem_write) begin
        mWdataNxt = data_out;
      end
      waitCntNxt       = '0;
      lastGrantDataNxt = 1'b1;
    end else if (grantInst) begin
      mAddrNxt         = inst_addr;
      mRdNxt           = 1'b1;
      mWrNxt           = 1'b0;
      waitCntNxt       = '0;
      lastGrantDataNxt = 1'b0;
    end else if (accDone || accTimeout) begin
      mRdNxt = 1'b0;
      mWrNxt = 1'b0;
      if (state == DATA) begin
        dataAckNxt = 1'b1;
        if (m_rd) begin
          dataInNxt = accDone ? m_rdata : '0;
        end
      end else begin
        instAckNxt = 1'b1;
        instrNxt   = accDone ? m_rdata : '0;
      end
      if (accTimeout) begin
        timeoutNxt = 1'b1;
      end
    end else if (state != IDLE) begin
      waitCntNxt = waitCnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst_addr;
  logic        inst_req;
  logic [31:0] instr;
  logic        inst_ack;
  logic [31:0] data_addr;
  logic [31:0] data_out;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] data_in;
  logic        data_ack;
  logic        stall;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_rd;
  logic        m_wr;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        timeout_err;

  int vecCnt = 0;
  int errCnt = 0;

  unified_mem_arbiter #(.WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset),
    .inst_addr(inst_addr), .inst_req(inst_req), .instr(instr), .inst_ack(inst_ack),
    .data_addr(data_addr), .data_out(data_out), .mem_read(mem_read), .mem_write(mem_write),
    .data_in(data_in), .data_ack(data_ack), .stall(stall),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr),
    .m_rdata(m_rdata), .m_ready(m_ready), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // strobe vector is {m_rd, m_wr, inst_ack, data_ack}
  task automatic test_reset();
    reset = 1'b1; inst_req = 1'b1; mem_read = 1'b1; m_ready = 1'b1;
    tick(); tick();
    vecCnt++;
    if ({m_rd, m_wr, inst_ack, data_ack, timeout_err} !== 5'b00000) begin
      errCnt++; $display("FAIL reset_flags: got %b want %b", {m_rd, m_wr, inst_ack, data_ack, timeout_err}, 5'b00000);
    end
    vecCnt++;
    if ({instr, data_in, m_addr, m_wdata} !== 128'h0) begin
      errCnt++; $display("FAIL reset_data: got %h want 0", {instr, data_in, m_addr, m_wdata});
    end
    vecCnt++;
    if (stall !== 1'b1) begin errCnt++; $display("FAIL reset_stall_req: got %b want 1", stall); end
    inst_req = 1'b0; mem_read = 1'b0; m_ready = 1'b0; reset = 1'b0;
    #1;
    vecCnt++;
    if (stall !== 1'b0) begin errCnt++; $display("FAIL reset_stall_idle: got %b want 0", stall); end
    tick();
  endtask

  task automatic test_fetch();
    tick();
    inst_addr = 32'h40; m_rdata = 32'h8C010004; m_ready = 1'b1; inst_req = 1'b1;
    #1;
    vecCnt++;
    if (stall !== 1'b1) begin errCnt++; $display("FAIL fetch_stall_c0: got %b want 1", stall); end
    tick();
    vecCnt++;
    if ({m_rd, m_wr, inst_ack, data_ack} !== 4'b1000 || m_addr !== 32'h40 || stall !== 1'b1) begin
      errCnt++; $display("FAIL fetch_c1: got strb=%b addr=%h stall=%b want strb=1000 addr=40 stall=1", {m_rd, m_wr, inst_ack, data_ack}, m_addr, stall);
    end
    tick();
    vecCnt++;
    if ({m_rd, m_wr, inst_ack, data_ack} !== 4'b0010 || instr !== 32'h8C010004 || stall !== 1'b0) begin
      errCnt++; $display("FAIL fetch_c2: got strb=%b instr=%h stall=%b want strb=0010 instr=8c010004 stall=0", {m_rd, m_wr, inst_ack, data_ack}, instr, stall);
    end
    inst_req = 1'b0;
    tick();
    vecCnt++;
    if ({m_rd, m_wr, inst_ack, data_ack} !== 4'b0000) begin
      errCnt++; $display("FAIL fetch_ack_pulse: got %b want 0000", {m_rd, m_wr, inst_ack, data_ack});
    end
  endtask

  task automatic test_simultaneous();
    tick();
    inst_addr = 32'h80; data_addr = 32'h200; m_rdata = 32'h11112222; m_ready = 1'b1;
    inst_req = 1'b1; mem_read = 1'b1;
    tick();
    vecCnt++;
    if ({m_rd, m_wr, inst_ack, data_ack} !== 4'b1000 || m_addr !== 32'h200) begin
      errCnt++; $display("FAIL simul_c1: got strb=%b addr=%h want 1000 addr=200", {m_rd, m_wr, inst_ack, data_ack}, m_addr);
    end
    tick();
    vecCnt++;
    if ({m_rd, m_wr, inst_ack, data_ack} !== 4'b0001 || data_in !== 32'h11112222 || stall !== 1'b1) begin
      errCnt++; $display("FAIL simul_c2: got strb=%b din=%h stall=%b want 0001 din=11112222 stall=1", {m_rd, m_wr, inst_ack, data_ack}, data_in, stall);
    end
    mem_read = 1'b0; m_rdata = 32'h33334444;
    tick();
    vecCnt++;
    if ({m_rd, m_wr, inst_ack, data_ack} !== 4'b1000 || m_addr !== 32'h80) begin
      errCnt++; $display("FAIL simul_c3: got strb=%b addr=%h want 1000 addr=80", {m_rd, m_wr, inst_ack, data_ack}, m_addr);
    end
    tick();
    vecCnt++;
    if ({m_rd, m_wr, inst_ack, data_ack} !== 4'b0010 || instr !== 32'h33334444 || data_in !== 32'h11112222) begin
      errCnt++; $display("FAIL simul_c4: got strb=%b instr=%h din=%h want 0010 instr=33334444 din=11112222", {m_rd, m_wr, inst_ack, data_ack}, instr, data_in);
    end
    inst_req = 1'b0;
    tick();
  endtask

  task automatic test_store_wait();
    tick();
    data_addr = 32'h100; data_out = 32'hCAFE; m_ready = 1'b0; m_rdata = 32'hBAD0BAD0; mem_write = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      vecCnt++;
      if ({m_rd, m_wr, inst_ack, data_ack} !== 4'b0100 || m_addr !== 32'h100 || m_wdata !== 32'hCAFE) begin
        errCnt++; $display("FAIL store_hold_c%0d: got strb=%b addr=%h wd=%h want 0100 addr=100 wd=cafe", k, {m_rd, m_wr, inst_ack, data_ack}, m_addr, m_wdata);
      end
      if (k == 4) m_ready = 1'b1;
    end
    tick();
    vecCnt++;
    if ({m_rd, m_wr, inst_ack, data_ack} !== 4'b0001 || data_in !== 32'h11112222) begin
      errCnt++; $display("FAIL store_ack: got strb=%b din=%h want 0001 din=11112222", {m_rd, m_wr, inst_ack, data_ack}, data_in);
    end
    mem_write = 1'b0;
    tick();
    vecCnt++;
    if ({m_rd, m_wr, inst_ack, data_ack, timeout_err} !== 5'b00000) begin
      errCnt++; $display("FAIL store_after: got %b want 00000", {m_rd, m_wr, inst_ack, data_ack, timeout_err});
    end
  endtask

  task automatic test_alternate();
    tick();
    inst_addr = 32'h90; data_addr = 32'h204; m_rdata = 32'h0A0A0A0A; m_ready = 1'b1;
    inst_req = 1'b1; mem_read = 1'b1;
    tick();
    vecCnt++;
    if ({m_rd, m_wr, inst_ack, data_ack} !== 4'b1000 || m_addr !== 32'h90) begin
      errCnt++; $display("FAIL alt_inst_first: got strb=%b addr=%h want 1000 addr=90", {m_rd, m_wr, inst_ack, data_ack}, m_addr);
    end
    tick();
    vecCnt++;
    if ({m_rd, m_wr, inst_ack, data_ack} !== 4'b0010 || instr !== 32'h0A0A0A0A) begin
      errCnt++; $display("FAIL alt_inst_ack: got strb=%b instr=%h want 0010 instr=0a0a0a0a", {m_rd, m_wr, inst_ack, data_ack}, instr);
    end
    inst_req = 1'b0; m_rdata = 32'h0B0B0B0B;
    tick();
    vecCnt++;
    if ({m_rd, m_wr, inst_ack, data_ack} !== 4'b1000 || m_addr !== 32'h204) begin
      errCnt++; $display("FAIL alt_data_grant: got strb=%b addr=%h want 1000 addr=204", {m_rd, m_wr, inst_ack, data_ack}, m_addr);
    end
    tick();
    vecCnt++;
    if ({m_rd, m_wr, inst_ack, data_ack} !== 4'b0001 || data_in !== 32'h0B0B0B0B) begin
      errCnt++; $display("FAIL alt_data_ack: got strb=%b din=%h want 0001 din=0b0b0b0b", {m_rd, m_wr, inst_ack, data_ack}, data_in);
    end
    mem_read = 1'b0;
    tick();
  endtask

  task automatic test_rw_both();
    tick();
    data_addr = 32'h208; data_out = 32'h12345678; m_rdata = 32'hFFFFFFFF; m_ready = 1'b1;
    mem_read = 1'b1; mem_write = 1'b1;
    tick();
    vecCnt++;
    if ({m_rd, m_wr, inst_ack, data_ack} !== 4'b0100 || m_wdata !== 32'h12345678 || m_addr !== 32'h208) begin
      errCnt++; $display("FAIL rw_store: got strb=%b wd=%h addr=%h want 0100 wd=12345678 addr=208", {m_rd, m_wr, inst_ack, data_ack}, m_wdata, m_addr);
    end
    tick();
    vecCnt++;
    if ({m_rd, m_wr, inst_ack, data_ack} !== 4'b0001 || data_in !== 32'h0B0B0B0B) begin
      errCnt++; $display("FAIL rw_ack: got strb=%b din=%h want 0001 din=0b0b0b0b", {m_rd, m_wr, inst_ack, data_ack}, data_in);
    end
    mem_read = 1'b0; mem_write = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    tick();
    data_addr = 32'h300; m_rdata = 32'hDEADBEEF; m_ready = 1'b0; mem_read = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      vecCnt++;
      if ({m_rd, data_ack, timeout_err} !== 3'b100) begin
        errCnt++; $display("FAIL timeout_wait_c%0d: got rd/ack/err=%b want 100", k, {m_rd, data_ack, timeout_err});
      end
    end
    tick();
    vecCnt++;
    if ({m_rd, m_wr, inst_ack, data_ack} !== 4'b0001 || data_in !== 32'h0 || timeout_err !== 1'b1) begin
      errCnt++; $display("FAIL timeout_ack: got strb=%b din=%h err=%b want 0001 din=0 err=1", {m_rd, m_wr, inst_ack, data_ack}, data_in, timeout_err);
    end
    mem_read = 1'b0;
    tick();
    inst_addr = 32'h48; m_rdata = 32'h77; m_ready = 1'b1; inst_req = 1'b1;
    tick();
    tick();
    vecCnt++;
    if (inst_ack !== 1'b1 || instr !== 32'h77 || timeout_err !== 1'b1) begin
      errCnt++; $display("FAIL timeout_sticky: got ack=%b instr=%h err=%b want ack=1 instr=77 err=1", inst_ack, instr, timeout_err);
    end
    inst_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    tick();
    inst_addr = 32'h44; m_ready = 1'b0; inst_req = 1'b1;
    tick();
    tick();
    vecCnt++;
    if ({m_rd, m_wr, inst_ack, data_ack} !== 4'b1000) begin
      errCnt++; $display("FAIL rstmid_pending: got %b want 1000", {m_rd, m_wr, inst_ack, data_ack});
    end
    reset = 1'b1;
    tick();
    vecCnt++;
    if ({m_rd, m_wr, inst_ack, data_ack, timeout_err} !== 5'b00000 || instr !== 32'h0) begin
      errCnt++; $display("FAIL rstmid_abandon: got flags=%b instr=%h want 00000 instr=0", {m_rd, m_wr, inst_ack, data_ack, timeout_err}, instr);
    end
    reset = 1'b0; m_ready = 1'b1; m_rdata = 32'h55;
    tick();
    vecCnt++;
    if ({m_rd, m_wr, inst_ack, data_ack} !== 4'b1000 || m_addr !== 32'h44) begin
      errCnt++; $display("FAIL rstmid_reissue: got strb=%b addr=%h want 1000 addr=44", {m_rd, m_wr, inst_ack, data_ack}, m_addr);
    end
    tick();
    vecCnt++;
    if ({m_rd, m_wr, inst_ack, data_ack} !== 4'b0010 || instr !== 32'h55) begin
      errCnt++; $display("FAIL rstmid_done: got strb=%b instr=%h want 0010 instr=55", {m_rd, m_wr, inst_ack, data_ack}, instr);
    end
    inst_req = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; inst_addr = '0; inst_req = 1'b0; data_addr = '0; data_out = '0;
    mem_read = 1'b0; mem_write = 1'b0; m_rdata = '0; m_ready = 1'b0;
    test_reset();
    test_fetch();
    test_simultaneous();
    test_store_wait();
    test_alternate();
    test_rw_both();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
